// File: rtl/rf_wb_arbiter_if.sv
// Handshake bundle between the WB stage, the multi-cycle unit, the decode
// stall query and the register file write port.
interface rf_wb_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  localparam int NREG = 2 ** ADDR_W;

  logic              p_valid;
  logic [ADDR_W-1:0] p_addr;
  logic [DATA_W-1:0] p_data;
  logic              p_ready;
  logic              m_valid;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_data;
  logic              m_ready;
  logic              iss_valid;
  logic [ADDR_W-1:0] iss_rd;
  logic              iss_ready;
  logic [ADDR_W-1:0] q_rs1;
  logic [ADDR_W-1:0] q_rs2;
  logic [ADDR_W-1:0] q_rd;
  logic              stall;
  logic              wb_en;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic [NREG-1:0]   busy_vec;

  modport slave (
    input  p_valid, p_addr, p_data, m_valid, m_addr, m_data,
    input  iss_valid, iss_rd, q_rs1, q_rs2, q_rd,
    output p_ready, m_ready, iss_ready, stall, wb_en, wb_addr, wb_data, busy_vec
  );

  modport master (
    output p_valid, p_addr, p_data, m_valid, m_addr, m_data,
    output iss_valid, iss_rd, q_rs1, q_rs2, q_rd,
    input  p_ready, m_ready, iss_ready, stall, wb_en, wb_addr, wb_data, busy_vec
  );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: pipeline (P) vs multi-cycle unit (M) with
// starvation guard, registered write stage and M-destination busy scoreboard.
module rf_wb_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int STARVE_MAX = 3
) (
  input  logic           clk,
  input  logic           rst,
  rf_wb_arbiter_if.slave bus
);
  localparam int NREG  = 2 ** ADDR_W;
  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};

  logic [CNT_W-1:0]  starve_cnt_r;
  logic [CNT_W-1:0]  starve_cnt_nxt_s;
  logic [NREG-1:0]   busy_r;
  logic [NREG-1:0]   busy_nxt_s;
  logic              wb_en_r;
  logic [ADDR_W-1:0] wb_addr_r;
  logic [DATA_W-1:0] wb_data_r;
  logic              force_m_s;
  logic              p_ready_s;
  logic              m_ready_s;
  logic              p_xfer_s;
  logic              m_xfer_s;
  logic              iss_ready_s;
  logic              iss_set_s;

  // Arbitration: P normally wins, M is forced through once it has been blocked STARVE_MAX times
  always_comb begin
    force_m_s   = bus.m_valid && (starve_cnt_r == CNT_MAX);
    p_ready_s   = !force_m_s;
    m_ready_s   = force_m_s || !bus.p_valid;
    p_xfer_s    = bus.p_valid && p_ready_s;
    m_xfer_s    = bus.m_valid && m_ready_s;
    iss_ready_s = !busy_r[bus.iss_rd] || (bus.iss_rd == ADDR_ZERO);
    iss_set_s   = bus.iss_valid && iss_ready_s && (bus.iss_rd != ADDR_ZERO);
  end

  // Starvation counter next value
  always_comb begin
    starve_cnt_nxt_s = starve_cnt_r;
    if (!bus.m_valid || m_xfer_s) begin
      starve_cnt_nxt_s = {CNT_W{1'b0}};
    end else if (starve_cnt_r != CNT_MAX) begin
      starve_cnt_nxt_s = starve_cnt_r + 1'b1;
    end else begin
      starve_cnt_nxt_s = starve_cnt_r;
    end
  end

  // Scoreboard next value; the set is applied last so a same-index issue beats an M clear
  always_comb begin
    busy_nxt_s = busy_r;
    if (m_xfer_s) begin
      busy_nxt_s[bus.m_addr] = 1'b0;
    end else begin
      busy_nxt_s = busy_r;
    end
    if (iss_set_s) begin
      busy_nxt_s[bus.iss_rd] = 1'b1;
    end else begin
      busy_nxt_s[bus.iss_rd] = busy_nxt_s[bus.iss_rd];
    end
    busy_nxt_s[0] = 1'b0;
  end

  // State and registered write stage; address/data hold when nothing transfers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt_r <= {CNT_W{1'b0}};
      busy_r       <= {NREG{1'b0}};
      wb_en_r      <= 1'b0;
      wb_addr_r    <= ADDR_ZERO;
      wb_data_r    <= {DATA_W{1'b0}};
    end else begin
      starve_cnt_r <= starve_cnt_nxt_s;
      busy_r       <= busy_nxt_s;
      if (p_xfer_s) begin
        wb_en_r   <= (bus.p_addr != ADDR_ZERO);
        wb_addr_r <= bus.p_addr;
        wb_data_r <= bus.p_data;
      end else if (m_xfer_s) begin
        wb_en_r   <= (bus.m_addr != ADDR_ZERO);
        wb_addr_r <= bus.m_addr;
        wb_data_r <= bus.m_data;
      end else begin
        wb_en_r <= 1'b0;
      end
    end
  end

  assign bus.p_ready   = p_ready_s;
  assign bus.m_ready   = m_ready_s;
  assign bus.iss_ready = iss_ready_s;
  assign bus.stall     = busy_r[bus.q_rs1] | busy_r[bus.q_rs2] | busy_r[bus.q_rd];
  assign bus.wb_en     = wb_en_r;
  assign bus.wb_addr   = wb_addr_r;
  assign bus.wb_data   = wb_data_r;
  assign bus.busy_vec  = busy_r;
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed vector table, async reset sequence, then
// randomized traffic against a behavioural winner/scoreboard model.
module tb_rf_wb_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 32;
  localparam int SMAX = 3;

  typedef struct {
    bit p_valid; logic [AW-1:0] p_addr; logic [DW-1:0] p_data;
    bit m_valid; logic [AW-1:0] m_addr; logic [DW-1:0] m_data;
    bit iss_valid; logic [AW-1:0] iss_rd;
    logic [AW-1:0] q_rs1, q_rs2, q_rd;
    bit e_p_ready, e_m_ready, e_iss_ready, e_stall, e_wb_en;
    logic [AW-1:0] e_wb_addr; logic [DW-1:0] e_wb_data; logic [NR-1:0] e_busy;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int total = 0;
  int bad = 0;

  int            mdl_starve;
  bit            mdl_busy [NR];
  bit            mdl_en;
  logic [AW-1:0] mdl_addr;
  logic [DW-1:0] mdl_data;

  vec_t tbl [17];

  always #5 clk = ~clk;

  rf_wb_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
  rf_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(bit pv, logic [AW-1:0] pa, logic [DW-1:0] pd,
                              bit mv, logic [AW-1:0] ma, logic [DW-1:0] md,
                              bit iv, logic [AW-1:0] ir,
                              logic [AW-1:0] r1, logic [AW-1:0] r2, logic [AW-1:0] rd,
                              bit epr, bit emr, bit eir, bit est,
                              bit een, logic [AW-1:0] ea, logic [DW-1:0] ed, logic [NR-1:0] eb);
    vec_t v;
    v.p_valid = pv; v.p_addr = pa; v.p_data = pd;
    v.m_valid = mv; v.m_addr = ma; v.m_data = md;
    v.iss_valid = iv; v.iss_rd = ir;
    v.q_rs1 = r1; v.q_rs2 = r2; v.q_rd = rd;
    v.e_p_ready = epr; v.e_m_ready = emr; v.e_iss_ready = eir; v.e_stall = est;
    v.e_wb_en = een; v.e_wb_addr = ea; v.e_wb_data = ed; v.e_busy = eb;
    return v;
  endfunction

  // Drive one cycle from posedge+1, check handshake mid-cycle, write stage after the edge
  task automatic apply(input vec_t v);
    bus.p_valid = v.p_valid; bus.p_addr = v.p_addr; bus.p_data = v.p_data;
    bus.m_valid = v.m_valid; bus.m_addr = v.m_addr; bus.m_data = v.m_data;
    bus.iss_valid = v.iss_valid; bus.iss_rd = v.iss_rd;
    bus.q_rs1 = v.q_rs1; bus.q_rs2 = v.q_rs2; bus.q_rd = v.q_rd;
    #4;
    chk("p_ready", 64'(bus.p_ready), 64'(v.e_p_ready));
    chk("m_ready", 64'(bus.m_ready), 64'(v.e_m_ready));
    chk("iss_ready", 64'(bus.iss_ready), 64'(v.e_iss_ready));
    chk("stall", 64'(bus.stall), 64'(v.e_stall));
    @(posedge clk); #1;
    chk("wb_en", 64'(bus.wb_en), 64'(v.e_wb_en));
    chk("wb_addr", 64'(bus.wb_addr), 64'(v.e_wb_addr));
    chk("wb_data", 64'(bus.wb_data), 64'(v.e_wb_data));
    chk("busy_vec", 64'(bus.busy_vec), 64'(v.e_busy));
  endtask

  task automatic model_reset();
    mdl_starve = 0;
    for (int i = 0; i < NR; i++) mdl_busy[i] = 1'b0;
    mdl_en = 1'b0; mdl_addr = '0; mdl_data = '0;
  endtask

  // Reference: pick a winner from the rules, then advance write stage, starvation count and scoreboard
  task automatic model_fill(inout vec_t v);
    bit force_m, iss_ok;
    int winner;
    force_m = v.m_valid && (mdl_starve >= SMAX);
    if (force_m) winner = 2;
    else if (v.p_valid) winner = 1;
    else if (v.m_valid) winner = 2;
    else winner = 0;
    iss_ok = (v.iss_rd == 0) || !mdl_busy[v.iss_rd];
    v.e_p_ready = !force_m;
    v.e_m_ready = force_m || !v.p_valid;
    v.e_iss_ready = iss_ok;
    v.e_stall = mdl_busy[v.q_rs1] || mdl_busy[v.q_rs2] || mdl_busy[v.q_rd];
    if (winner == 1) begin
      mdl_en = (v.p_addr != 0); mdl_addr = v.p_addr; mdl_data = v.p_data;
    end else if (winner == 2) begin
      mdl_en = (v.m_addr != 0); mdl_addr = v.m_addr; mdl_data = v.m_data;
    end else begin
      mdl_en = 1'b0;
    end
    if (v.m_valid && winner != 2) mdl_starve = (mdl_starve + 1 > SMAX) ? SMAX : mdl_starve + 1;
    else mdl_starve = 0;
    if (winner == 2) mdl_busy[v.m_addr] = 1'b0;
    if (v.iss_valid && iss_ok && v.iss_rd != 0) mdl_busy[v.iss_rd] = 1'b1;
    v.e_wb_en = mdl_en; v.e_wb_addr = mdl_addr; v.e_wb_data = mdl_data;
    for (int i = 0; i < NR; i++) v.e_busy[i] = mdl_busy[i];
  endtask

  initial begin
    bit p_pend, m_pend, p_v, m_v;
    logic [AW-1:0] p_a, m_a;
    logic [DW-1:0] p_d, m_d;

    // P only, then contention (P,P,P,M,P), scoreboard, double issue, x0
    tbl[0]  = mk(1, 5, 32'hDEADBEEF, 0, 0, 0,           0, 0, 0, 0, 0, 1, 0, 1, 0, 1, 5, 32'hDEADBEEF, 32'h0);
    tbl[1]  = mk(0, 0, 0,            0, 0, 0,           0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 5, 32'hDEADBEEF, 32'h0);
    tbl[2]  = mk(1, 3, 32'h11111111, 1, 4, 32'h44444444, 0, 0, 0, 0, 0, 1, 0, 1, 0, 1, 3, 32'h11111111, 32'h0);
    tbl[3]  = mk(1, 3, 32'h22222222, 1, 4, 32'h44444444, 0, 0, 0, 0, 0, 1, 0, 1, 0, 1, 3, 32'h22222222, 32'h0);
    tbl[4]  = mk(1, 3, 32'h33333333, 1, 4, 32'h44444444, 0, 0, 0, 0, 0, 1, 0, 1, 0, 1, 3, 32'h33333333, 32'h0);
    tbl[5]  = mk(1, 3, 32'h55555555, 1, 4, 32'h44444444, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 4, 32'h44444444, 32'h0);
    tbl[6]  = mk(1, 3, 32'h55555555, 0, 0, 0,           0, 0, 0, 0, 0, 1, 0, 1, 0, 1, 3, 32'h55555555, 32'h0);
    tbl[7]  = mk(0, 0, 0,            0, 0, 0,           1, 7, 0, 0, 0, 1, 1, 1, 0, 0, 3, 32'h55555555, 32'h80);
    tbl[8]  = mk(0, 0, 0,            0, 0, 0,           0, 0, 7, 0, 0, 1, 1, 1, 1, 0, 3, 32'h55555555, 32'h80);
    tbl[9]  = mk(0, 0, 0,            1, 7, 32'h77777777, 0, 0, 7, 0, 0, 1, 1, 1, 1, 1, 7, 32'h77777777, 32'h0);
    tbl[10] = mk(0, 0, 0,            0, 0, 0,           0, 0, 7, 0, 0, 1, 1, 1, 0, 0, 7, 32'h77777777, 32'h0);
    tbl[11] = mk(0, 0, 0,            1, 7, 32'h88888888, 1, 7, 0, 0, 0, 1, 1, 1, 0, 1, 7, 32'h88888888, 32'h80);
    tbl[12] = mk(0, 0, 0,            0, 0, 0,           1, 9, 0, 0, 0, 1, 1, 1, 0, 0, 7, 32'h88888888, 32'h280);
    tbl[13] = mk(0, 0, 0,            0, 0, 0,           1, 9, 0, 0, 0, 1, 1, 0, 0, 0, 7, 32'h88888888, 32'h280);
    tbl[14] = mk(1, 0, 32'h12345678, 0, 0, 0,           0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 32'h12345678, 32'h280);
    tbl[15] = mk(0, 0, 0,            0, 0, 0,           1, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 32'h12345678, 32'h280);
    tbl[16] = mk(0, 0, 0,            0, 0, 0,           0, 0, 0, 0, 9, 1, 1, 1, 1, 0, 0, 32'h12345678, 32'h280);

    bus.p_valid = 1'b0; bus.p_addr = '0; bus.p_data = '0;
    bus.m_valid = 1'b0; bus.m_addr = '0; bus.m_data = '0;
    bus.iss_valid = 1'b0; bus.iss_rd = '0;
    bus.q_rs1 = '0; bus.q_rs2 = '0; bus.q_rd = '0;

    #2 rst = 1'b1;
    #1;
    chk("rst_wb_en", 64'(bus.wb_en), 64'd0);
    chk("rst_wb_addr", 64'(bus.wb_addr), 64'd0);
    chk("rst_wb_data", 64'(bus.wb_data), 64'd0);
    chk("rst_busy", 64'(bus.busy_vec), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 17; i++) apply(tbl[i]);

    // Async reset in the middle of back-to-back P traffic with M waiting
    bus.p_valid = 1'b1; bus.p_addr = 5'd2; bus.p_data = 32'hA5A5A5A5;
    bus.m_valid = 1'b1; bus.m_addr = 5'd9; bus.m_data = 32'h99999999;
    bus.iss_valid = 1'b0; bus.iss_rd = '0; bus.q_rs1 = '0; bus.q_rs2 = '0; bus.q_rd = '0;
    @(posedge clk); #1;
    chk("t1_pre_wb_en", 64'(bus.wb_en), 64'd1);
    chk("t1_pre_wb_data", 64'(bus.wb_data), 64'hA5A5A5A5);
    bus.p_data = 32'h5A5A5A5A;
    #2 rst = 1'b1;
    #1;
    chk("t1_wb_en", 64'(bus.wb_en), 64'd0);
    chk("t1_wb_addr", 64'(bus.wb_addr), 64'd0);
    chk("t1_wb_data", 64'(bus.wb_data), 64'd0);
    chk("t1_busy", 64'(bus.busy_vec), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();

    // Continued contention right after reset, then random traffic
    p_pend = 1'b1; p_v = 1'b1; p_a = 5'd2; p_d = 32'h5A5A5A5A;
    m_pend = 1'b1; m_v = 1'b1; m_a = 5'd9; m_d = 32'h99999999;
    for (int k = 0; k < 600; k++) begin
      vec_t v;
      if (!p_pend) begin
        p_v = (k < 6) ? 1'b1 : 1'($urandom_range(0, 1));
        p_a = 5'($urandom_range(0, 15));
        p_d = $urandom;
      end
      if (!m_pend) begin
        m_v = (k < 6) ? 1'b1 : 1'($urandom_range(0, 1));
        m_a = 5'($urandom_range(0, 15));
        m_d = $urandom;
      end
      v = mk(p_v, p_a, p_d, m_v, m_a, m_d,
             ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 15)),
             5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)),
             0, 0, 0, 0, 0, '0, '0, '0);
      model_fill(v);
      apply(v);
      p_pend = p_v && !v.e_p_ready;
      m_pend = m_v && !v.e_m_ready;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
